// File: rtl/mm_pkg.sv
// Shared constants and state type for the row-at-a-time matrix-multiply sequencer.
package mm_pkg;

  localparam int DIM       = 16;
  localparam int INT_BITS  = 7;
  localparam int FRAC_BITS = 9;
  localparam int AW_A      = $clog2(DIM * DIM);
  localparam int AW_B      = $clog2(DIM);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    OUT,
    DONE
  } mm_sched_state_t;

endpackage

// File: rtl/mm_sched_dly.sv
// MEM_LAT-deep delay line aligning {mac_en, mac_first} with SRAM read data.
module mm_sched_dly #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       flush_i,
  input  logic [1:0] din_i,
  output logic [1:0] dout_o
);

  logic [1:0] sr_q [MEM_LAT];

  // NOTE: every stage is cleared by flush so a cancelled run leaves no stray MAC strobes behind.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      for (int s = 0; s < MEM_LAT; s++) sr_q[s] <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int s = 1; s < MEM_LAT; s++) sr_q[s] <= sr_q[s-1];
    end
  end

  assign dout_o = sr_q[MEM_LAT-1];

endmodule

// File: rtl/mm_row_sched.sv
// Row-at-a-time sequencer for C = A x B over a shared row of DIM MAC lanes.
// Optional perf counters are enabled with MM_ROW_SCHED_PERF_EN.
module mm_row_sched #(
  parameter int DIM     = mm_pkg::DIM,
  parameter int MEM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        a_rd_en,
  output logic [$clog2(DIM*DIM)-1:0]  a_addr,
  output logic                        b_rd_en,
  output logic [$clog2(DIM)-1:0]      b_addr,
  output logic                        mac_en,
  output logic                        mac_first,
  output logic                        row_valid,
  input  logic                        row_ready,
  output logic [$clog2(DIM)-1:0]      row_idx
`ifdef MM_ROW_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_cycles,
  output logic [31:0]                 perf_stalls
`endif
);

  import mm_pkg::*;

  localparam int B_W = $clog2(DIM);
  localparam int C_W = $clog2(MEM_LAT + 1);

  mm_sched_state_t state_q, state_d;
  logic [B_W-1:0]  i_q, i_d;
  logic [B_W-1:0]  k_q, k_d;
  logic [C_W-1:0]  cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments only; the next-state logic below is purely combinational.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      i_d     = '0;
      k_d     = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = FEED;
            i_d     = '0;
            k_d     = '0;
          end
        end
        FEED: begin
          if (k_q == B_W'(DIM - 1)) begin
            state_d = DRAIN;
            k_d     = '0;
            cnt_d   = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == C_W'(MEM_LAT - 1)) state_d = OUT;
          else                            cnt_d   = cnt_q + 1'b1;
        end
        OUT: begin
          if (row_ready) begin
            if (i_q == B_W'(DIM - 1)) begin
              state_d = DONE;
            end else begin
              state_d = FEED;
              i_d     = i_q + 1'b1;
              k_d     = '0;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          i_d     = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign a_rd_en   = (state_q == FEED);
  assign b_rd_en   = a_rd_en;
  assign a_addr    = {i_q, k_q};
  assign b_addr    = k_q;
  assign row_valid = (state_q == OUT);
  assign row_idx   = i_q;

  // The MAC controls follow the read strobe through the delay line, never the FSM state.
  logic [1:0] dly_out;

  mm_sched_dly #(.MEM_LAT(MEM_LAT)) u_dly (
    .clk     (clk),
    .flush_i (abort | rst),
    .din_i   ({a_rd_en, a_rd_en && (k_q == '0)}),
    .dout_o  (dly_out)
  );

  assign mac_en    = dly_out[1];
  assign mac_first = dly_out[0];

`ifdef MM_ROW_SCHED_PERF_EN
  logic        start_acc;
  logic [31:0] perf_cycles_q, perf_stalls_q;

  assign start_acc = (state_q == IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy && (perf_cycles_q != '1))
        perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == OUT) && !row_ready && (perf_stalls_q != '1))
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_mm_row_sched.sv
// Bench for mm_row_sched: instance 0 with MEM_LAT=1, instance 1 with MEM_LAT=3,
// checked every cycle against a queue-of-expected-cycles model plus literal timing points.
module tb_mm_row_sched;
  import mm_pkg::*;

  localparam int NCYC = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst [2], start [2], abort [2], row_ready [2];
  logic            busy [2], done [2], a_rd_en [2], b_rd_en [2];
  logic            mac_en [2], mac_first [2], row_valid [2];
  logic [AW_A-1:0] a_addr [2];
  logic [AW_B-1:0] b_addr [2], row_idx [2];
`ifdef MM_ROW_SCHED_PERF_EN
  logic [31:0]     perf_cycles [2], perf_stalls [2];
`endif

  mm_row_sched #(.DIM(DIM), .MEM_LAT(1)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]), .busy(busy[0]),
    .done(done[0]), .a_rd_en(a_rd_en[0]), .a_addr(a_addr[0]), .b_rd_en(b_rd_en[0]),
    .b_addr(b_addr[0]), .mac_en(mac_en[0]), .mac_first(mac_first[0]),
    .row_valid(row_valid[0]), .row_ready(row_ready[0]), .row_idx(row_idx[0])
`ifdef MM_ROW_SCHED_PERF_EN
    , .perf_cycles(perf_cycles[0]), .perf_stalls(perf_stalls[0])
`endif
  );

  mm_row_sched #(.DIM(DIM), .MEM_LAT(3)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]), .busy(busy[1]),
    .done(done[1]), .a_rd_en(a_rd_en[1]), .a_addr(a_addr[1]), .b_rd_en(b_rd_en[1]),
    .b_addr(b_addr[1]), .mac_en(mac_en[1]), .mac_first(mac_first[1]),
    .row_valid(row_valid[1]), .row_ready(row_ready[1]), .row_idx(row_idx[1])
`ifdef MM_ROW_SCHED_PERF_EN
    , .perf_cycles(perf_cycles[1]), .perf_stalls(perf_stalls[1])
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int n);
    return (n == 0) ? 1 : 3;
  endfunction

  // One record per expected busy cycle; the OUT record is held while row_ready is low.
  typedef struct {
    bit rd;
    bit first;
    bit valid;
    bit dn;
    int addr;
    int idx;
  } exp_t;

  exp_t     mq [2][$];
  bit [1:0] hist [2][4];

  task automatic build_run(input int n);
    for (int r = 0; r < DIM; r++) begin
      for (int k = 0; k < DIM; k++)
        mq[n].push_back('{rd: 1'b1, first: (k == 0), valid: 1'b0, dn: 1'b0, addr: r * DIM + k, idx: r});
      for (int d = 0; d < lat_of(n); d++)
        mq[n].push_back('{rd: 1'b0, first: 1'b0, valid: 1'b0, dn: 1'b0, addr: 0, idx: r});
      mq[n].push_back('{rd: 1'b0, first: 1'b0, valid: 1'b1, dn: 1'b0, addr: 0, idx: r});
    end
    mq[n].push_back('{rd: 1'b0, first: 1'b0, valid: 1'b0, dn: 1'b1, addr: 0, idx: DIM - 1});
  endtask

  task automatic model_step(input int n);
    exp_t     e;
    bit       b;
    bit [1:0] h;
    b = (mq[n].size() > 0);
    if (b) e = mq[n][0];
    else   e = '{default: 0};
    h = hist[n][lat_of(n) - 1];
    check($sformatf("t%0t n%0d ctl{busy,done,ard,brd,valid,mac,first}", $time, n),
          {busy[n], done[n], a_rd_en[n], b_rd_en[n], row_valid[n], mac_en[n], mac_first[n]},
          {b, e.dn, e.rd, e.rd, e.valid, h[1], h[0]});
    if (e.rd)
      check($sformatf("t%0t n%0d addr{a,b}", $time, n), {a_addr[n], b_addr[n]},
            {AW_A'(e.addr), AW_B'(e.addr % DIM)});
    if (b)
      check($sformatf("t%0t n%0d row_idx", $time, n), row_idx[n], e.idx);
    // advance the model to the next cycle using the inputs seen at the coming edge
    if (rst[n]) begin
      mq[n].delete();
      for (int j = 0; j < 4; j++) hist[n][j] = '0;
      return;
    end
    if (abort[n]) begin
      for (int j = 0; j < 4; j++) hist[n][j] = '0;
      if (b) begin
        mq[n].delete();
        return;
      end
    end else begin
      for (int j = 3; j > 0; j--) hist[n][j] = hist[n][j-1];
      hist[n][0] = {e.rd, e.rd & e.first};
    end
    if (!b) begin
      if (start[n] && !abort[n]) build_run(n);
    end else if (!(e.valid && !row_ready[n])) begin
      void'(mq[n].pop_front());
    end
  endtask

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) model_step(n);
  end

  // Per-cycle observations of the most recent run, indexed by cycle (start seen ending cycle 0).
  bit o_busy [NCYC], o_valid [NCYC], o_rd [NCYC], o_mac [NCYC], o_first [NCYC], o_done [NCYC];
  int o_addr [NCYC], o_baddr [NCYC], o_idx [NCYC];

  task automatic run(input int n, input int stall_at, input int stall_len, input int abort_at,
                     input int rst_at, input int xs_a, input int xs_b,
                     output int done_cyc, output int low_cyc);
    done_cyc = -1;
    low_cyc  = -1;
    @(posedge clk); #1;
    start[n] = 1'b1;
    for (int c = 1; c < NCYC; c++) begin
      @(posedge clk); #1;
      start[n]     = (c == xs_a) || (c == xs_b);
      row_ready[n] = !((c >= stall_at) && (c < stall_at + stall_len));
      abort[n]     = (c == abort_at);
      rst[n]       = (c == rst_at);
      @(negedge clk);
      o_busy[c]  = busy[n];
      o_valid[c] = row_valid[n];
      o_rd[c]    = a_rd_en[n];
      o_mac[c]   = mac_en[n];
      o_first[c] = mac_first[n];
      o_done[c]  = done[n];
      o_addr[c]  = int'(a_addr[n]);
      o_baddr[c] = int'(b_addr[n]);
      o_idx[c]   = int'(row_idx[n]);
      if (done[n] && done_cyc < 0) done_cyc = c;
      if (!busy[n] && low_cyc < 0) low_cyc = c;
      if (low_cyc >= 0 && c >= low_cyc + 16) break;
    end
    @(posedge clk); #1;
    start[n] = 1'b0; abort[n] = 1'b0; rst[n] = 1'b0; row_ready[n] = 1'b1;
  endtask

  int d, l;

  initial begin
    for (int n = 0; n < 2; n++) begin
      rst[n] = 1'b1; start[n] = 1'b0; abort[n] = 1'b0; row_ready[n] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 2; n++)
      check($sformatf("reset n%0d outputs", n),
            {busy[n], done[n], a_rd_en[n], b_rd_en[n], mac_en[n], mac_first[n], row_valid[n],
             a_addr[n], b_addr[n], row_idx[n]}, '0);

    // 1: full run, row_ready always high
    run(0, -1, 0, -1, -1, -1, -1, d, l);
    check("t1 done cycle", d, 289);
    check("t1 busy low cycle", l, 290);
    check("t1 first read {rd,addr}", {o_rd[1], o_addr[1]}, {1'b1, 32'd0});
    check("t1 row0 k15 addr", o_addr[16], 15);
    check("t1 row1 k0 {addr,baddr}", {o_addr[19], o_baddr[19]}, {32'd16, 32'd0});
    check("t1 row1 k15 baddr", o_baddr[34], 15);
    check("t1 last read addr", o_addr[286], 255);
    check("t1 last OUT {valid,idx}", {o_valid[288], o_idx[288]}, {1'b1, 32'd15});

    // 2: five-cycle stall at row 3's OUT
    run(0, 72, 5, -1, -1, -1, -1, d, l);
    check("t2 done cycle", d, 294);
    for (int c = 72; c < 77; c++)
      check($sformatf("t2 stall c%0d {valid,idx,rd}", c), {o_valid[c], o_idx[c], o_rd[c]},
            {1'b1, 32'd3, 1'b0});
    check("t2 row4 k0 {rd,addr}", {o_rd[78], o_addr[78]}, {1'b1, 32'd64});
`ifdef MM_ROW_SCHED_PERF_EN
    check("t2 perf_stalls", perf_stalls[0], 5);
    check("t2 perf_cycles", perf_cycles[0], 294);
`endif

    // 3: MEM_LAT=3 instance
    run(1, -1, 0, -1, -1, -1, -1, d, l);
    check("t3 done cycle", d, 321);
    check("t3 busy low cycle", l, 322);
    check("t3 mac_en c3", o_mac[3], 0);
    check("t3 {mac,first} c4", {o_mac[4], o_first[4]}, 2'b11);
    check("t3 {mac,first} c5", {o_mac[5], o_first[5]}, 2'b10);
    check("t3 {mac,valid} c19", {o_mac[19], o_valid[19]}, 2'b10);
    check("t3 {mac,valid} c20", {o_mac[20], o_valid[20]}, 2'b01);

    // 4: abort at row 2, k=7, then restart
    run(0, -1, 0, 44, -1, -1, -1, d, l);
    check("t4 no done", d, -1);
    check("t4 abort-cycle addr", o_addr[44], 39);
    check("t4 after abort {busy,mac}", {o_busy[45], o_mac[45]}, 2'b00);
    run(0, -1, 0, -1, -1, -1, -1, d, l);
    check("t4 restart {rd,addr}", {o_rd[1], o_addr[1]}, {1'b1, 32'd0});
    check("t4 restart done cycle", d, 289);

    // 5: start while busy is ignored; start+abort in IDLE stays IDLE
    run(0, -1, 0, -1, -1, 5, 100, d, l);
    check("t5 done cycle", d, 289);
    check("t5 busy low cycle", l, 290);
    @(posedge clk); #1;
    start[0] = 1'b1; abort[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0; abort[0] = 1'b0;
    @(negedge clk);
    check("t5 start+abort idle busy", busy[0], 0);

    // 6: rst during an OUT cycle, then a clean run
    run(0, -1, 0, -1, 18, -1, -1, d, l);
    check("t6 OUT before rst", o_valid[18], 1);
    check("t6 outputs after rst",
          {o_busy[19], o_done[19], o_rd[19], o_valid[19], o_mac[19], o_first[19],
           o_addr[19], o_baddr[19], o_idx[19]}, '0);
    check("t6 no done", d, -1);
    run(0, -1, 0, -1, -1, -1, -1, d, l);
    check("t6 rerun done cycle", d, 289);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
